quad_input_conditioner: RTL



---
 rtl/quad_input_conditioner.sv | 100 ++++++++++
 1 files changed

// File: rtl/quad_input_conditioner.sv
// quad_input_conditioner: sync + filter encoder pins A/B/Z, decode quadrature steps, index, illegal transitions
// Ports: clk/rst_n clock and async active-low reset; pins raw {Z,B,A}; count time base;
//        pins_clean filtered pins; step/dir quadrature step pulse and direction; index Z falling pulse;
//        illegal double-transition pulse; err_count saturating illegal count; edge_time count at last step;
//        armed startup complete.
module quad_input_conditioner #(
   parameter int FILTER_LEN = 4,
   parameter int TIME_W     = 51,
   parameter int ERR_W      = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [2:0]        pins,
   input  logic [TIME_W-1:0] count,
   output logic [2:0]        pins_clean,
   output logic              step,
   output logic              dir,
   output logic              index,
   output logic              illegal,
   output logic [ERR_W-1:0]  err_count,
   output logic [TIME_W-1:0] edge_time,
   output logic              armed
);
   localparam logic [7:0] FL_M1 = 8'(FILTER_LEN - 1);
   logic [2:0]        sync1_q, sync2_q, clean_q, clean_d, prev_q;
   logic [7:0]        cnt_q [3];
   logic [7:0]        cnt_d [3];
   logic [1:0]        st_q;
   logic              armed_q, step_q, dir_q, index_q, illegal_q;
   logic [ERR_W-1:0]  err_q;
   logic [TIME_W-1:0] time_q;
   logic [1:0]        ab_chg;
   logic              mv, bad, dec;
   always_comb begin
      clean_d = clean_q;
      for (int i = 0; i < 3; i++) begin
         cnt_d[i] = cnt_q[i] + 8'd1;
         if (sync2_q[i] == clean_q[i]) cnt_d[i] = '0;
         else if (cnt_q[i] == FL_M1) begin
            clean_d[i] = sync2_q[i];
            cnt_d[i]   = '0;
         end
      end
   end
   // A is bit 0, B is bit 1; for a single-bit Gray move, previous A equal to new B means a decrement
   assign ab_chg = clean_q[1:0] ^ prev_q[1:0];
   assign mv     = ^ab_chg;
   assign bad    = &ab_chg;
   assign dec    = ~(prev_q[0] ^ clean_q[1]);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q   <= '0;
         sync2_q   <= '0;
         clean_q   <= 3'b100;
         prev_q    <= 3'b100;
         for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
         st_q      <= '0;
         armed_q   <= 1'b0;
         step_q    <= 1'b0;
         dir_q     <= 1'b0;
         index_q   <= 1'b0;
         illegal_q <= 1'b0;
         err_q     <= '0;
         time_q    <= '0;
      end else begin
         sync1_q <= pins;
         sync2_q <= sync1_q;
         if (!armed_q) begin
            // startup: third edge takes the synchronised pins unfiltered so no spurious events fire
            st_q <= st_q + 2'd1;
            if (st_q == 2'd2) begin
               armed_q <= 1'b1;
               st_q    <= st_q;
               clean_q <= sync2_q;
               prev_q  <= sync2_q;
            end
         end else begin
            clean_q   <= clean_d;
            for (int i = 0; i < 3; i++) cnt_q[i] <= cnt_d[i];
            prev_q    <= clean_q;
            step_q    <= mv;
            illegal_q <= bad;
            index_q   <= prev_q[2] & ~clean_q[2];
            if (mv) begin
               dir_q  <= dec;
               time_q <= count;
            end
            if (bad && !(&err_q)) err_q <= err_q + 1'b1;
         end
      end
   end
   assign pins_clean = clean_q;
   assign step       = step_q;
   assign dir        = dir_q;
   assign index      = index_q;
   assign illegal    = illegal_q;
   assign err_count  = err_q;
   assign edge_time  = time_q;
   assign armed      = armed_q;
endmodule
